// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer
//   Store-and-forward packet framer in front of the aurora_module s_axi_tx_* stream.
//   Each user packet is buffered completely. The framer then sends one header word
//   {MAGIC, seq, len_words} followed by the payload. A frame starts only while the
//   channel is up. A channel drop during a frame aborts it, and the rest of that
//   frame's payload is flushed from the buffer.
//   All logic is in the Aurora user-clock domain: i_user_clk = o_user_clk and
//   i_rst = o_sys_rst, a synchronous active-high reset.
// Ports
//   i_data/i_keep/i_last/i_valid/o_ready : user packet input (keep used on last word only)
//   i_channel_up                         : Aurora channel status
//   m_axi_tx_t{data,keep,last,valid,ready}: AXI-Stream output to aurora_module
//   o_trunc_err                          : pulse, packet cut at MAX_PKT_WORDS
//   o_abort                              : pulse, frame aborted by channel drop
//   o_seq                                : sequence number of the next frame to start
// Build option
//   AURORA_TX_CKSUM_EN : appends a trailer word holding the 32-bit sum of the emitted payload.
module aurora_tx_framer #(
    parameter int         FIFO_DEPTH    = 512,
    parameter int         LEN_DEPTH     = 8,
    parameter int         MAX_PKT_WORDS = 256,
    parameter logic [7:0] MAGIC         = 8'hA5
) (
    input  logic        i_user_clk,
    input  logic        i_rst,
    input  logic [0:31] i_data,
    input  logic [0:3]  i_keep,
    input  logic        i_last,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_channel_up,
    output logic [0:31] m_axi_tx_tdata,
    output logic [0:3]  m_axi_tx_tkeep,
    output logic        m_axi_tx_tlast,
    output logic        m_axi_tx_tvalid,
    input  logic        m_axi_tx_tready,
    output logic        o_trunc_err,
    output logic        o_abort,
    output logic [7:0]  o_seq
);
    localparam int PAW = $clog2(FIFO_DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_WORDS);
    localparam logic [PAW:0] PAY_ONE = 1;
    localparam logic [LAW:0] LEN_ONE = 1;
`ifdef AURORA_TX_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, HDR, PAY, TAIL, DRAIN} state_t;

    logic [0:31] pay_mem [FIFO_DEPTH];
    logic [19:0] len_mem [LEN_DEPTH];   // {len_words[15:0], last keep}
    logic [PAW:0] pay_wr, pay_rd;
    logic [LAW:0] len_wr, len_rd;
    logic         pay_full, len_full, len_empty;

    logic [15:0] word_cnt, cnt_next;
    logic        discard, accept, at_max, pay_push, len_push;
    logic [3:0]  desc_keep;

    state_t      state;
    logic [15:0] rem;                   // payload words still to leave the FIFO
    logic [0:3]  keep_r;
    logic [7:0]  seq;
    logic        last_next;
    logic [0:3]  pay_keep;
    logic [0:31] pay_head;
    logic [19:0] len_head;

    always_comb begin
        pay_full  = (pay_wr[PAW] != pay_rd[PAW]) && (pay_wr[PAW-1:0] == pay_rd[PAW-1:0]);
        len_full  = (len_wr[LAW] != len_rd[LAW]) && (len_wr[LAW-1:0] == len_rd[LAW-1:0]);
        len_empty = (len_wr == len_rd);
        o_ready   = ~i_rst & ~pay_full & ~len_full;
        accept    = i_valid & o_ready;
        cnt_next  = word_cnt + 16'd1;
        at_max    = (cnt_next == MAX_LEN);
        pay_push  = accept & ~discard;
        len_push  = pay_push & (i_last | at_max);
        // A truncated packet ends on a full word.
        desc_keep = i_last ? i_keep : 4'hF;
        pay_head  = pay_mem[pay_rd[PAW-1:0]];
        len_head  = len_mem[len_rd[LAW-1:0]];
        last_next = (rem == 16'd1);
        pay_keep  = last_next ? keep_r : 4'hF;
    end

    // Input stage: buffer writes
    always_ff @(posedge i_user_clk) begin
        if (pay_push) pay_mem[pay_wr[PAW-1:0]] <= i_data;
        if (len_push) len_mem[len_wr[LAW-1:0]] <= {cnt_next, desc_keep};
    end

    always_ff @(posedge i_user_clk) begin
        if (i_rst) begin
            word_cnt    <= 16'd0;
            discard     <= 1'b0;
            pay_wr      <= '0;
            len_wr      <= '0;
            o_trunc_err <= 1'b0;
        end else begin
            o_trunc_err <= 1'b0;
            if (accept) begin
                if (discard) begin
                    // Words after a truncation are dropped through the packet's last word.
                    if (i_last) discard <= 1'b0;
                end else begin
                    pay_wr <= pay_wr + PAY_ONE;
                    if (i_last || at_max) begin
                        len_wr   <= len_wr + LEN_ONE;
                        word_cnt <= 16'd0;
                        if (at_max && !i_last) begin
                            o_trunc_err <= 1'b1;
                            discard     <= 1'b1;
                        end
                    end else begin
                        word_cnt <= cnt_next;
                    end
                end
            end
        end
    end

`ifdef AURORA_TX_CKSUM_EN
    function automatic logic [0:31] mask_bytes(input logic [0:31] d, input logic [0:3] k);
        logic [0:31] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = k[b] ? d[8*b +: 8] : 8'h00;
        return m;
    endfunction

    logic [0:31] cksum;
    // The sum follows the words as they are loaded into the output register.
    always_ff @(posedge i_user_clk) begin
        if (i_channel_up && m_axi_tx_tready) begin
            if (state == HDR)
                cksum <= mask_bytes(pay_head, pay_keep);
            else if (state == PAY && rem != 16'd0)
                cksum <= cksum + mask_bytes(pay_head, pay_keep);
        end
    end
`endif

    // Output stage: frame FSM with registered AXI outputs
    always_ff @(posedge i_user_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            rem             <= 16'd0;
            keep_r          <= 4'h0;
            seq             <= 8'd0;
            pay_rd          <= '0;
            len_rd          <= '0;
            m_axi_tx_tdata  <= 32'd0;
            m_axi_tx_tkeep  <= 4'h0;
            m_axi_tx_tlast  <= 1'b0;
            m_axi_tx_tvalid <= 1'b0;
            o_abort         <= 1'b0;
        end else begin
            o_abort <= 1'b0;
            case (state)
                IDLE: if (!len_empty && i_channel_up) begin
                    len_rd          <= len_rd + LEN_ONE;
                    rem             <= len_head[19:4];
                    keep_r          <= len_head[3:0];
                    m_axi_tx_tdata  <= {MAGIC, seq, len_head[19:4]};
                    m_axi_tx_tkeep  <= 4'hF;
                    m_axi_tx_tlast  <= 1'b0;
                    m_axi_tx_tvalid <= 1'b1;
                    state           <= HDR;
                end
                HDR, PAY, TAIL: begin
                    if (!i_channel_up) begin
                        m_axi_tx_tvalid <= 1'b0;
                        m_axi_tx_tlast  <= 1'b0;
                        o_abort         <= 1'b1;
                        state           <= DRAIN;
                    end else if (m_axi_tx_tready) begin
                        if (state == HDR) seq <= seq + 8'd1;
                        if (state == TAIL || (state == PAY && rem == 16'd0)) begin
`ifdef AURORA_TX_CKSUM_EN
                            if (state == PAY) begin
                                m_axi_tx_tdata <= cksum;
                                m_axi_tx_tkeep <= 4'hF;
                                m_axi_tx_tlast <= 1'b1;
                                state          <= TAIL;
                            end else begin
                                m_axi_tx_tvalid <= 1'b0;
                                m_axi_tx_tlast  <= 1'b0;
                                state           <= IDLE;
                            end
`else
                            m_axi_tx_tvalid <= 1'b0;
                            m_axi_tx_tlast  <= 1'b0;
                            state           <= IDLE;
`endif
                        end else begin
                            // Move the next payload word into the output register.
                            pay_rd         <= pay_rd + PAY_ONE;
                            rem            <= rem - 16'd1;
                            m_axi_tx_tdata <= pay_head;
                            m_axi_tx_tkeep <= pay_keep;
                            m_axi_tx_tlast <= last_next & ~CKSUM_EN;
                            state          <= PAY;
                        end
                    end
                end
                DRAIN: begin
                    if (rem != 16'd0) begin
                        pay_rd <= pay_rd + PAY_ONE;
                        rem    <= rem - 16'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_seq = seq;

endmodule
